// File: rtl/core_if_stage.sv
// core_if_stage -- instruction fetch stage with a single outstanding request.
//
// Purpose:
//   Issues sequential fetch requests to instruction memory. It accepts
//   redirects (flush) from the branch unit and presents fetched instructions
//   in the IF/ID register. A one-entry skid buffer catches a response that
//   arrives while ID is stalled and IF/ID is already occupied.
//
// Ports:
//   clock            sole clock, rising edge
//   reset            synchronous, active-high
//   next_pc[63:0]    redirect target, used only when flush=1
//   flush            redirect request from branch unit
//   stall            ID cannot accept; IF/ID holds
//   imem_req_valid   fetch request valid (registers only)
//   imem_req_addr    fetch address (= fetch_pc)
//   imem_req_ready   memory accepts request this cycle
//   imem_resp_valid  instruction word returned this cycle
//   imem_resp_data   returned instruction word
//   pc4[63:0]        fetch_pc + 4 (wraps), to branch unit
//   if_valid         IF/ID holds a live instruction
//   if_pc[63:0]      PC of the instruction in IF/ID
//   if_inst[31:0]    instruction in IF/ID
module core_if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] next_pc,
  input  logic        flush,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [63:0] pc4,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst
);

  // FETCH: nothing outstanding. WAIT: response will be delivered.
  // DROP: response will be discarded (a redirect overtook it).
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [63:0] fetch_pc_reg;
  logic [63:0] req_pc_reg;
  logic        if_valid_reg;
  logic [63:0] if_pc_reg;
  logic [31:0] if_inst_reg;
  logic        skid_valid_reg;
  logic [63:0] skid_pc_reg;
  logic [31:0] skid_inst_reg;

  logic        req_valid;
  logic        accept;
  logic        deliver;

  // No new request while the skid buffer is full: there would be nowhere
  // to put its response if ID stays stalled.
  assign req_valid = (state_reg == ST_FETCH) && !skid_valid_reg;
  assign accept    = req_valid && imem_req_ready;
  assign deliver   = (state_reg == ST_WAIT) && imem_resp_valid && !flush;

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = fetch_pc_reg;
  assign pc4            = fetch_pc_reg + 64'd4;
  assign if_valid       = if_valid_reg;
  assign if_pc          = if_pc_reg;
  assign if_inst        = if_inst_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_FETCH;
      fetch_pc_reg   <= RESET_PC;
      req_pc_reg     <= 64'd0;
      if_valid_reg   <= 1'b0;
      if_pc_reg      <= 64'd0;
      if_inst_reg    <= 32'd0;
      skid_valid_reg <= 1'b0;
      skid_pc_reg    <= 64'd0;
      skid_inst_reg  <= 32'd0;
    end else begin
      // Fetch address
      if (flush) begin
        fetch_pc_reg <= next_pc;
      end else if (accept) begin
        fetch_pc_reg <= fetch_pc_reg + 64'd4;
      end

      if (accept) begin
        req_pc_reg <= fetch_pc_reg;
      end

      // Request tracking
      case (state_reg)
        ST_FETCH: begin
          if (accept) begin
            state_reg <= flush ? ST_DROP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Any response retires the request; a flush without a response
          // leaves it outstanding but marked for discard.
          if (imem_resp_valid) begin
            state_reg <= ST_FETCH;
          end else if (flush) begin
            state_reg <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (imem_resp_valid) begin
            state_reg <= ST_FETCH;
          end
        end
        default: state_reg <= ST_FETCH;
      endcase

      // IF/ID register and skid buffer
      if (flush) begin
        if_valid_reg   <= 1'b0;
        skid_valid_reg <= 1'b0;
      end else if (deliver) begin
        if (!stall || !if_valid_reg) begin
          if_valid_reg <= 1'b1;
          if_pc_reg    <= req_pc_reg;
          if_inst_reg  <= imem_resp_data;
        end else begin
          skid_valid_reg <= 1'b1;
          skid_pc_reg    <= req_pc_reg;
          skid_inst_reg  <= imem_resp_data;
        end
      end else if (!stall) begin
        if (skid_valid_reg) begin
          if_valid_reg   <= 1'b1;
          if_pc_reg      <= skid_pc_reg;
          if_inst_reg    <= skid_inst_reg;
          skid_valid_reg <= 1'b0;
        end else begin
          if_valid_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_if_stage.sv
// tb_core_if_stage -- randomized self-checking bench for core_if_stage.
// The bench plays instruction memory and keeps a transaction-level model:
// one optional outstanding request (pc + live flag) and a queue of
// delivered instructions whose head is the IF/ID content (depth 2 = skid).
module tb_core_if_stage;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clock;
  logic        reset;
  logic [63:0] next_pc;
  logic        flush;
  logic        stall;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [63:0] pc4;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  core_if_stage #(.RESET_PC(RESET_PC)) dut (
    .clock           (clock),
    .reset           (reset),
    .next_pc         (next_pc),
    .flush           (flush),
    .stall           (stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .pc4             (pc4),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  int          check_count = 0;
  int          error_count = 0;

  logic [63:0] m_fetch_pc;
  logic        m_out;
  logic [63:0] m_out_pc;
  logic        m_live;
  int          mem_wait;
  ent_t        m_q[$];
  logic [63:0] dlog[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, then
  // advance the model to what the coming edge should produce.
  task automatic step(input logic rst, input logic fl, input logic st,
                      input logic rdy, input logic [63:0] npc,
                      input logic rv, input logic [31:0] rd);
    logic exp_req;
    logic acc;
    logic resp;
    logic dlv;
    ent_t e;
    @(negedge clock);
    reset           = rst;
    flush           = fl;
    stall           = st;
    imem_req_ready  = rdy;
    next_pc         = npc;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    #1;
    exp_req = !m_out && (m_q.size() < 2);
    check("req_valid", 64'(imem_req_valid), 64'(exp_req));
    check("req_addr", imem_req_addr, m_fetch_pc);
    check("pc4", pc4, m_fetch_pc + 64'd4);
    check("if_valid", 64'(if_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("if_pc", if_pc, m_q[0].pc);
      check("if_inst", 64'(if_inst), 64'(m_q[0].inst));
    end
    if (rst) begin
      m_fetch_pc = RESET_PC;
      m_out      = 1'b0;
      m_live     = 1'b0;
      mem_wait   = 0;
      m_q.delete();
    end else begin
      acc  = exp_req && rdy;
      resp = m_out && rv;
      dlv  = resp && m_live && !fl;
      if (fl) begin
        m_q.delete();
      end else begin
        if (!st && m_q.size() > 0) void'(m_q.pop_front());
        if (dlv) begin
          e.pc   = m_out_pc;
          e.inst = rd;
          m_q.push_back(e);
          dlog.push_back(m_out_pc);
        end
      end
      if (resp) begin
        m_out = 1'b0;
      end else if (acc) begin
        m_out    = 1'b1;
        m_out_pc = m_fetch_pc;
        m_live   = !fl;
        mem_wait = $urandom_range(0, 2);
      end else if (m_out) begin
        if (fl) m_live = 1'b0;
        if (mem_wait > 0) mem_wait--;
      end
      if (fl) m_fetch_pc = npc;
      else if (acc) m_fetch_pc = m_fetch_pc + 64'd4;
    end
  endtask

  initial begin
    logic        r_rst, r_fl, r_st, r_rdy, r_rv;
    logic [63:0] r_npc;
    logic [31:0] r_rd;

    reset = 1'b1; flush = 1'b0; stall = 1'b0; next_pc = 64'd0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    repeat (3) @(posedge clock);
    m_fetch_pc = RESET_PC; m_out = 1'b0; m_out_pc = 64'd0; m_live = 1'b0;
    mem_wait = 0;

    // Reset state
    @(negedge clock); #1;
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_pc", if_pc, 64'd0);
    check("rst_if_inst", 64'(if_inst), 64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd1);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_pc4", pc4, 64'h4);

    // Back-to-back sequential fetch, immediate responses, no stall
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, m_out, 32'h1000 + m_out_pc[31:0]);
    check("seq_len", 64'(dlog.size() >= 3), 64'd1);
    if (dlog.size() >= 3) begin
      check("seq_pc0", dlog[0], 64'h0);
      check("seq_pc1", dlog[1], 64'h4);
      check("seq_pc2", dlog[2], 64'h8);
    end

    // Drain, then redirect to the top of the address space
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, m_out, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0);
    @(posedge clock); #1;
    check("wrap_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pc4", pc4, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b0, 32'h0);
    @(posedge clock); #1;
    check("wrap_next_addr", imem_req_addr, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 32'h1234_5678);
    @(posedge clock); #1;
    check("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Skid: stall with IF/ID occupied while a response arrives
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 32'hDEAD_BEEF);
    @(posedge clock); #1;
    check("skid_req_valid", 64'(imem_req_valid), 64'd0);
    check("skid_hold_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 32'h0);
    @(posedge clock); #1;
    check("skid_if_inst", 64'(if_inst), 64'hDEAD_BEEF);
    check("skid_resume", 64'(imem_req_valid), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_fl  = ($urandom_range(0, 99) < 8);
      r_st  = ($urandom_range(0, 99) < 30);
      r_rdy = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 3))
        0:       r_npc = 64'hFFFF_FFFF_FFFF_FFFC;
        1:       r_npc = 64'hFFFF_FFFF_FFFF_FFF8;
        default: r_npc = {$urandom, $urandom};
      endcase
      r_rv = m_out ? (mem_wait == 0) : ($urandom_range(0, 9) == 0);
      r_rd = $urandom;
      step(r_rst, r_fl, r_st, r_rdy, r_npc, r_rv, r_rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
